// File: rtl/mouse_cursor_display.sv
// Cursor overlay: 16x16 arrow sprite at a once-per-frame latched mouse position,
// with a short fill-colour flash after each left-button press.
module mouse_cursor_display #(
    parameter int          SPR_W        = 16,
    parameter int          SPR_H        = 16,
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [11:0] FILL_COLOR   = 12'hFFF,
    parameter logic [11:0] CLICK_COLOR  = 12'hF80,
    parameter logic [11:0] EDGE_COLOR   = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic [9:0]  mouse_x,
    input  logic [9:0]  mouse_y,
    input  logic        mouse_left,
    input  logic        cursor_on,
    output logic        en_mouse_display,
    output logic [11:0] mouse_pixel
);

    localparam int          FW     = $clog2(FLASH_FRAMES + 1);
    localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [1:0]  C_EDGE = 2'd1;
    localparam logic [1:0]  C_FILL = 2'd2;

    logic [9:0]    lx_q, lx_d;
    logic [9:0]    ly_q, ly_d;
    logic          len_q, len_d;
    logic          vb_q;
    logic          left_q;
    logic [FW-1:0] flash_q, flash_d;
    logic          en_q, en_d;
    logic [11:0]   pix_q, pix_d;

    logic          vb;
    logic          latch;
    logic          press;
    logic          hit;
    logic [3:0]    dx4, dy4;
    logic [1:0]    code;
    logic [10:0]   h11, v11, lx11, ly11;

    // Arrow: left edge full height, diagonal edge and fill in the upper 12 rows.
    function automatic logic [1:0] spr_code(input logic [3:0] r, input logic [3:0] c);
        if (c == 4'd0)
            return C_EDGE;
        else if (r <= 4'd11 && c == r)
            return C_EDGE;
        else if (r <= 4'd11 && c < r)
            return C_FILL;
        else
            return 2'd0;
    endfunction

    assign vb    = (v_cnt >= 10'(V_ACTIVE));
    assign latch = vb & ~vb_q;
    assign press = mouse_left & ~left_q;

    always_comb begin
        lx_d  = lx_q;
        ly_d  = ly_q;
        len_d = len_q;
        if (latch) begin
            lx_d  = (mouse_x > H_LAST) ? H_LAST : mouse_x;
            ly_d  = (mouse_y > V_LAST) ? V_LAST : mouse_y;
            len_d = cursor_on;
        end
    end

    // A press reloads even on a latch clock, so that frame is not counted down.
    always_comb begin
        flash_d = flash_q;
        if (press)
            flash_d = FW'(FLASH_FRAMES);
        else if (latch && flash_q != '0)
            flash_d = flash_q - FW'(1);
    end

    assign h11  = {1'b0, h_cnt};
    assign v11  = {1'b0, v_cnt};
    assign lx11 = {1'b0, lx_q};
    assign ly11 = {1'b0, ly_q};
    assign dx4  = h_cnt[3:0] - lx_q[3:0];
    assign dy4  = v_cnt[3:0] - ly_q[3:0];
    assign code = spr_code(dy4, dx4);

    // The H_ACTIVE bound stops a sprite near the right edge spilling into blanking.
    assign hit = (h11 >= lx11) && (h11 < lx11 + 11'(SPR_W))
              && (v11 >= ly11) && (v11 < ly11 + 11'(SPR_H))
              && (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE))
              && len_q;

    always_comb begin
        en_d  = 1'b0;
        pix_d = 12'h000;
        if (hit) begin
            if (code == C_EDGE) begin
                en_d  = 1'b1;
                pix_d = EDGE_COLOR;
            end else if (code == C_FILL) begin
                en_d  = 1'b1;
                pix_d = (flash_q != '0) ? CLICK_COLOR : FILL_COLOR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lx_q    <= '0;
            ly_q    <= '0;
            len_q   <= 1'b0;
            vb_q    <= 1'b0;
            left_q  <= 1'b0;
            flash_q <= '0;
            en_q    <= 1'b0;
            pix_q   <= 12'h000;
        end else begin
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            len_q   <= len_d;
            vb_q    <= vb;
            left_q  <= mouse_left;
            flash_q <= flash_d;
            en_q    <= en_d;
            pix_q   <= pix_d;
        end
    end

    assign en_mouse_display = en_q;
    assign mouse_pixel      = pix_q;

endmodule

// File: tb/tb_mouse_cursor_display.sv
// Bench for mouse_cursor_display: counters are driven directly in compressed
// frames (a latch pulse followed by a handful of probed pixels).
module tb_mouse_cursor_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  h_cnt = '0;
    logic [9:0]  v_cnt = '0;
    logic [9:0]  mouse_x = '0;
    logic [9:0]  mouse_y = '0;
    logic        mouse_left = 1'b0;
    logic        cursor_on = 1'b0;
    logic        en_mouse_display;
    logic [11:0] mouse_pixel;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        en;
        logic [11:0] pix;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [12:0] obs_q[$];

    mouse_cursor_display dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .h_cnt            (h_cnt),
        .v_cnt            (v_cnt),
        .mouse_x          (mouse_x),
        .mouse_y          (mouse_y),
        .mouse_left       (mouse_left),
        .cursor_on        (cursor_on),
        .en_mouse_display (en_mouse_display),
        .mouse_pixel      (mouse_pixel)
    );

    always #5 clk = ~clk;

    task automatic probe(input logic [9:0] h, input logic [9:0] v,
                         input logic e, input logic [11:0] p, input string nm);
        exp_t ex;
        @(negedge clk);
        h_cnt = h;
        v_cnt = v;
        ex.en = e; ex.pix = p; ex.name = nm;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        obs_q.push_back({en_mouse_display, mouse_pixel});
    endtask

    task automatic frame_latch(input bit with_press);
        @(negedge clk); h_cnt = 10'd0; v_cnt = 10'd479;
        @(negedge clk); v_cnt = 10'd480; if (with_press) mouse_left = 1'b1;
        @(negedge clk); v_cnt = 10'd481; mouse_left = 1'b0;
        @(negedge clk);
    endtask

    task automatic click();
        @(negedge clk); mouse_left = 1'b1;
        @(negedge clk); mouse_left = 1'b0;
    endtask

    task automatic test_reset();
        exp_t ex;
        rst_n = 1'b0; mouse_x = 10'd100; mouse_y = 10'd50; cursor_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({en_mouse_display, mouse_pixel} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_out: got en=%b pix=%h, expected en=0 pix=000", en_mouse_display, mouse_pixel);
        end
        @(negedge clk); rst_n = 1'b1;
        probe(10'd100, 10'd50, 1'b0, 12'h000, "first_frame_origin");
        probe(10'd103, 10'd55, 1'b0, 12'h000, "first_frame_fill");
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); vectors++;
            if (obs_q.pop_front() !== {ex.en, ex.pix}) begin
                miscompares++;
                $display("FAIL %s: en=%b pix=%h expected en=%b pix=%h", ex.name, en_mouse_display, mouse_pixel, ex.en, ex.pix);
            end
        end
    endtask

    task automatic test_basic();
        exp_t ex;
        logic [12:0] ob;
        frame_latch(1'b0);
        probe(10'd100, 10'd50, 1'b1, 12'h000, "tip_edge");
        probe(10'd103, 10'd55, 1'b1, 12'hFFF, "fill");
        probe(10'd99,  10'd50, 1'b0, 12'h000, "left_of_sprite");
        probe(10'd116, 10'd50, 1'b0, 12'h000, "right_of_sprite");
        probe(10'd115, 10'd50, 1'b0, 12'h000, "row0_transparent");
        probe(10'd100, 10'd65, 1'b1, 12'h000, "last_row_edge");
        probe(10'd100, 10'd66, 1'b0, 12'h000, "below_sprite");
        probe(10'd111, 10'd61, 1'b1, 12'h000, "diag_row11");
        probe(10'd112, 10'd62, 1'b0, 12'h000, "diag_row12_clear");
        probe(10'd101, 10'd61, 1'b1, 12'hFFF, "fill_row11");
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); ob = obs_q.pop_front(); vectors++;
            if (ob !== {ex.en, ex.pix}) begin
                miscompares++;
                $display("FAIL %s: en=%b pix=%h expected en=%b pix=%h", ex.name, ob[12], ob[11:0], ex.en, ex.pix);
            end
        end
    endtask

    task automatic test_no_tear();
        exp_t ex;
        logic [12:0] ob;
        @(negedge clk); v_cnt = 10'd200; mouse_x = 10'd300; mouse_y = 10'd300;
        probe(10'd100, 10'd50,  1'b1, 12'h000, "old_pos_kept");
        probe(10'd300, 10'd300, 1'b0, 12'h000, "new_pos_hidden");
        frame_latch(1'b0);
        probe(10'd300, 10'd300, 1'b1, 12'h000, "new_pos_drawn");
        probe(10'd100, 10'd50,  1'b0, 12'h000, "old_pos_gone");
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); ob = obs_q.pop_front(); vectors++;
            if (ob !== {ex.en, ex.pix}) begin
                miscompares++;
                $display("FAIL %s: en=%b pix=%h expected en=%b pix=%h", ex.name, ob[12], ob[11:0], ex.en, ex.pix);
            end
        end
    endtask

    task automatic test_edges();
        exp_t ex;
        logic [12:0] ob;
        mouse_x = 10'd635; mouse_y = 10'd470;
        frame_latch(1'b0);
        probe(10'd635, 10'd470, 1'b1, 12'h000, "edge_corner_tip");
        probe(10'd639, 10'd474, 1'b1, 12'h000, "edge_last_col_diag");
        probe(10'd639, 10'd475, 1'b1, 12'hFFF, "edge_last_col_fill");
        probe(10'd640, 10'd475, 1'b0, 12'h000, "edge_past_h");
        probe(10'd0,   10'd470, 1'b0, 12'h000, "edge_no_hwrap");
        probe(10'd635, 10'd0,   1'b0, 12'h000, "edge_no_vwrap");
        mouse_x = 10'd700;
        frame_latch(1'b0);
        probe(10'd639, 10'd470, 1'b1, 12'h000, "clamp_x_tip");
        probe(10'd638, 10'd470, 1'b0, 12'h000, "clamp_x_left");
        probe(10'd639, 10'd479, 1'b1, 12'h000, "clamp_x_bottom");
        mouse_y = 10'd600;
        frame_latch(1'b0);
        probe(10'd639, 10'd479, 1'b1, 12'h000, "clamp_y_tip");
        probe(10'd639, 10'd478, 1'b0, 12'h000, "clamp_y_above");
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); ob = obs_q.pop_front(); vectors++;
            if (ob !== {ex.en, ex.pix}) begin
                miscompares++;
                $display("FAIL %s: en=%b pix=%h expected en=%b pix=%h", ex.name, ob[12], ob[11:0], ex.en, ex.pix);
            end
        end
    endtask

    task automatic test_flash();
        exp_t ex;
        logic [12:0] ob;
        mouse_x = 10'd100; mouse_y = 10'd50;
        frame_latch(1'b0);
        probe(10'd103, 10'd55, 1'b1, 12'hFFF, "flash_idle");
        click();
        probe(10'd103, 10'd55, 1'b1, 12'hF80, "flash_press_frame");
        probe(10'd100, 10'd50, 1'b1, 12'h000, "flash_edge_unchanged");
        for (int k = 1; k <= 8; k++) begin
            frame_latch(1'b0);
            probe(10'd103, 10'd55, 1'b1, (k <= 7) ? 12'hF80 : 12'hFFF, $sformatf("flash_f%0d", k));
        end
        click();
        for (int k = 1; k <= 4; k++) begin
            frame_latch(1'b0);
            probe(10'd103, 10'd55, 1'b1, 12'hF80, $sformatf("retrig_pre_f%0d", k));
        end
        click();
        for (int k = 1; k <= 8; k++) begin
            frame_latch(1'b0);
            probe(10'd103, 10'd55, 1'b1, (k <= 7) ? 12'hF80 : 12'hFFF, $sformatf("retrig_f%0d", k));
        end
        frame_latch(1'b1);
        probe(10'd103, 10'd55, 1'b1, 12'hF80, "coinc_frame0");
        for (int k = 1; k <= 8; k++) begin
            frame_latch(1'b0);
            probe(10'd103, 10'd55, 1'b1, (k <= 7) ? 12'hF80 : 12'hFFF, $sformatf("coinc_f%0d", k));
        end
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); ob = obs_q.pop_front(); vectors++;
            if (ob !== {ex.en, ex.pix}) begin
                miscompares++;
                $display("FAIL %s: en=%b pix=%h expected en=%b pix=%h", ex.name, ob[12], ob[11:0], ex.en, ex.pix);
            end
        end
    endtask

    task automatic test_cursor_off();
        exp_t ex;
        logic [12:0] ob;
        cursor_on = 1'b0;
        frame_latch(1'b0);
        probe(10'd100, 10'd50, 1'b0, 12'h000, "off_tip");
        cursor_on = 1'b1;
        probe(10'd100, 10'd50, 1'b0, 12'h000, "off_tip_after_on");
        probe(10'd103, 10'd55, 1'b0, 12'h000, "off_fill_after_on");
        frame_latch(1'b0);
        probe(10'd100, 10'd50, 1'b1, 12'h000, "on_next_frame");
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); ob = obs_q.pop_front(); vectors++;
            if (ob !== {ex.en, ex.pix}) begin
                miscompares++;
                $display("FAIL %s: en=%b pix=%h expected en=%b pix=%h", ex.name, ob[12], ob[11:0], ex.en, ex.pix);
            end
        end
    endtask

    task automatic test_midframe_reset();
        exp_t ex;
        logic [12:0] ob;
        probe(10'd100, 10'd52, 1'b1, 12'h000, "pre_reset_active");
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({en_mouse_display, mouse_pixel} !== 13'h0) begin
            miscompares++;
            $display("FAIL async_reset_clear: en=%b pix=%h expected en=0 pix=000", en_mouse_display, mouse_pixel);
        end
        @(negedge clk); rst_n = 1'b1;
        probe(10'd100, 10'd52, 1'b0, 12'h000, "post_reset_hidden");
        probe(10'd103, 10'd55, 1'b0, 12'h000, "post_reset_fill_hidden");
        frame_latch(1'b0);
        probe(10'd100, 10'd52, 1'b1, 12'h000, "after_latch_visible");
        probe(10'd103, 10'd55, 1'b1, 12'hFFF, "after_latch_fill_no_flash");
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); ob = obs_q.pop_front(); vectors++;
            if (ob !== {ex.en, ex.pix}) begin
                miscompares++;
                $display("FAIL %s: en=%b pix=%h expected en=%b pix=%h", ex.name, ob[12], ob[11:0], ex.en, ex.pix);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_tear();
        test_edges();
        test_flash();
        test_cursor_off();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
